// File: rtl/stream_pkg.sv
// stream_pkg: shared defaults and helpers for the stream width converters.
// Imported by stream_width_upsizer and its sibling stream stages.
package stream_pkg;

    localparam int DEF_IN_WIDTH = 32;
    localparam int DEF_RATIO    = 4;

    function automatic int cnt_w(input int ratio);
        int w;
        w = $clog2(ratio);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/stream_width_upsizer.sv
// stream_width_upsizer: packs RATIO narrow beats into one wide registered word.
// Output handshake matches pipeline_reg so the two chain back to back.
module stream_width_upsizer
    import stream_pkg::*;
#(
    parameter int IN_WIDTH = DEF_IN_WIDTH,
    parameter int RATIO    = DEF_RATIO
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IN_WIDTH-1:0]       in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [IN_WIDTH*RATIO-1:0] out_data,
    output logic [RATIO-1:0]          out_keep,
    output logic                      out_last
);

    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int CW        = cnt_w(RATIO);

    localparam logic [CW-1:0]    CNT_MAX  = CW'(RATIO - 1);
    localparam logic [RATIO-1:0] KEEP_ONE = RATIO'(1);

    logic [OUT_WIDTH-1:0] acc_q, acc_d;
    logic [RATIO-1:0]     acc_keep_q, acc_keep_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic [RATIO-1:0]     out_keep_q, out_keep_d;
    logic                 out_last_q, out_last_d;
    logic                 out_valid_q, out_valid_d;

    logic                 accept;
    logic                 complete;
    logic [OUT_WIDTH-1:0] acc_ins;
    logic [RATIO-1:0]     keep_ins;

    // Output slot frees up either when empty or when the sink takes it now.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign complete = accept && (in_last || (cnt_q == CNT_MAX));

    always_comb begin
        acc_ins = acc_q;
        acc_ins[int'(cnt_q)*IN_WIDTH +: IN_WIDTH] = in_data;
        keep_ins = acc_keep_q | (KEEP_ONE << cnt_q);
    end

    always_comb begin
        acc_d       = acc_q;
        acc_keep_d  = acc_keep_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (complete) begin
            out_data_d  = acc_ins;
            out_keep_d  = keep_ins;
            out_last_d  = in_last;
            out_valid_d = 1'b1;
            acc_d       = '0;
            acc_keep_d  = '0;
            cnt_d       = '0;
        end else if (accept) begin
            acc_d      = acc_ins;
            acc_keep_d = keep_ins;
            cnt_d      = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            acc_keep_q  <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            acc_keep_q  <= acc_keep_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_stream_width_upsizer.sv
// tb_stream_width_upsizer: directed cases plus random traffic
// checked against a scoreboard of expected words.
module tb_stream_width_upsizer;

    localparam int IW = 32;
    localparam int R  = 4;
    localparam int OW = IW * R;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [OW-1:0] out_data;
    logic [R-1:0]  out_keep;
    logic          out_last;

    always #5 clk = ~clk;

    stream_width_upsizer #(
        .IN_WIDTH(IW),
        .RATIO   (R)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_keep (out_keep),
        .out_last (out_last)
    );

    typedef struct packed {
        logic [OW-1:0] d;
        logic [R-1:0]  k;
        logic          l;
    } word_t;

    word_t         sb_q[$];
    int            checks = 0;
    int            errors = 0;
    int            cycles = 0;
    logic [OW-1:0] m_data;
    logic [R-1:0]  m_keep;
    int            m_cnt;
    bit            s_acc, s_fire, s_rdy;
    bit            hold_prev, exp_valid;
    word_t         prev;

    task automatic chk(input string tag, input logic [OW-1:0] got,
                       input logic [OW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_data    = '0;
        m_keep    = '0;
        m_cnt     = 0;
        hold_prev = 1'b0;
        exp_valid = 1'b0;
        sb_q.delete();
    endtask

    // One clock: called just after a falling edge with inputs set.
    task automatic cyc();
        word_t w;
        word_t nw;
        #1;
        if (hold_prev) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_data", out_data, prev.d);
            chk("hold_keep", out_keep, prev.k);
            chk("hold_last", out_last, prev.l);
        end
        if (exp_valid) chk("latency", out_valid, 1'b1);
        s_rdy  = in_ready;
        s_acc  = in_valid && in_ready;
        s_fire = out_valid && out_ready;
        chk("in_ready", in_ready, !out_valid || out_ready);
        if (s_fire) begin
            if (sb_q.size() == 0) begin
                chk("spurious_word", out_valid, 1'b0);
            end else begin
                w = sb_q.pop_front();
                chk("word_data", out_data, w.d);
                chk("word_keep", out_keep, w.k);
                chk("word_last", out_last, w.l);
            end
        end
        exp_valid = 1'b0;
        if (s_acc) begin
            m_data[m_cnt*IW +: IW] = in_data;
            m_keep[m_cnt] = 1'b1;
            if (in_last || m_cnt == R - 1) begin
                nw.d = m_data;
                nw.k = m_keep;
                nw.l = in_last;
                sb_q.push_back(nw);
                m_data    = '0;
                m_keep    = '0;
                m_cnt     = 0;
                exp_valid = 1'b1;
            end else begin
                m_cnt++;
            end
        end
        hold_prev = out_valid && !out_ready;
        prev.d = out_data;
        prev.k = out_keep;
        prev.l = out_last;
        cycles++;
        @(negedge clk);
    endtask

    task automatic send(input logic [IW-1:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int n = 0; n < 100; n++) begin
            cyc();
            if (s_acc) break;
        end
        if (!s_acc) chk("send_timeout", s_rdy, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        int c0;
        int beats;
        int guard;
        model_clear();

        #2;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, '0);
        chk("rst_keep", out_keep, '0);
        chk("rst_last", out_last, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while a word is half built
        out_ready = 1'b1;
        send(32'hA0, 1'b0);
        send(32'hA1, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_keep", out_keep, '0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        send(32'hB0, 1'b0);
        send(32'hB1, 1'b0);
        send(32'hB2, 1'b0);
        send(32'hB3, 1'b0);
        chk("t1_data", out_data,
            128'h000000B3_000000B2_000000B1_000000B0);
        chk("t1_keep", out_keep, 4'b1111);

        // Streaming, two words back to back
        c0 = cycles;
        send(32'h11, 1'b0);
        send(32'h22, 1'b0);
        send(32'h33, 1'b0);
        send(32'h44, 1'b0);
        chk("t2_valid", out_valid, 1'b1);
        chk("t2_data", out_data,
            128'h00000044_00000033_00000022_00000011);
        chk("t2_last", out_last, 1'b0);
        send(32'h55, 1'b0);
        send(32'h66, 1'b0);
        send(32'h77, 1'b0);
        send(32'h88, 1'b0);
        chk("t2_rate", cycles - c0, 8);
        chk("t2_data2", out_data,
            128'h00000088_00000077_00000066_00000055);

        // Early last
        send(32'hAA, 1'b0);
        send(32'hBB, 1'b1);
        chk("t3_keep", out_keep, 4'b0011);
        chk("t3_last", out_last, 1'b1);
        chk("t3_data", out_data,
            128'h00000000_00000000_000000BB_000000AA);

        // Single-beat word
        send(32'h5, 1'b1);
        chk("t4_keep", out_keep, 4'b0001);
        chk("t4_data", out_data, 128'h5);
        chk("t4_last", out_last, 1'b1);

        // Back-pressure then simultaneous drain and reload
        send(32'h1, 1'b0);
        send(32'h2, 1'b0);
        send(32'h3, 1'b0);
        out_ready = 1'b0;
        send(32'h4, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'h99;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t5_stall", s_rdy, 1'b0);
        end
        out_ready = 1'b1;
        cyc();
        chk("t5_accept", s_acc, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("t5_valid", out_valid, 1'b1);
        chk("t5_data", out_data, 128'h99);
        chk("t5_keep", out_keep, 4'b0001);
        cyc();

        // Random valid/ready/last traffic
        beats = 0;
        guard = 0;
        while (beats < 10000 && guard < 60000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            in_last   = ($urandom_range(0, 4) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cyc();
            if (s_acc) beats++;
            guard++;
        end
        chk("t6_beats", beats, 10000);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        chk("t6_drained", sb_q.size(), 0);
        chk("t6_idle", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
